// File: rtl/z80_word_mem_seq.sv
// Two-byte memory sequencer for Z80 16-bit transfers: low byte at nn, then high byte at nn+1,
// with wait-state stretching, little-endian word assembly and a z80fi-style trace.
module z80_word_mem_seq #(
    parameter int unsigned T_STATES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_wait,
    output logic [15:0] trace_addr,
    output logic [15:0] trace_addr2,
    output logic [7:0]  trace_data,
    output logic [7:0]  trace_data2,
    output logic        trace_write
);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    localparam logic [3:0] CntLast = 4'(T_STATES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q;
    logic [15:0] addr_hi;
    logic        write_q;
    logic [15:0] wdata_q;
    logic [7:0]  lo_q;
    logic [15:0] resp_rdata_q;
    logic [15:0] trace_addr_q, trace_addr2_q;
    logic [7:0]  trace_data_q, trace_data2_q;
    logic        trace_write_q;
    logic        at_last;
    logic        lo_done, hi_done;

    assign addr_hi = addr_q + 16'd1;
    // mem_wait only matters once the minimum access length has elapsed
    assign at_last = (cnt_q >= CntLast);
    assign lo_done = (state_q == StLo) && at_last && !mem_wait;
    assign hi_done = (state_q == StHi) && at_last && !mem_wait;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_addr   = 16'h0000;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_wdata  = 8'h00;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = StLo;
                    cnt_d   = 4'd0;
                end
            end
            StLo, StHi: begin
                mem_addr  = (state_q == StLo) ? addr_q : addr_hi;
                mem_rd    = !write_q;
                mem_wr    = write_q;
                if (write_q) begin
                    mem_wdata = (state_q == StLo) ? wdata_q[7:0] : wdata_q[15:8];
                end
                if (!at_last) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (!mem_wait) begin
                    state_d = (state_q == StLo) ? StHi : StDone;
                    cnt_d   = 4'd0;
                end
            end
            StDone: begin
                resp_valid = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q        <= 16'h0000;
            write_q       <= 1'b0;
            wdata_q       <= 16'h0000;
            lo_q          <= 8'h00;
            resp_rdata_q  <= 16'h0000;
            trace_addr_q  <= 16'h0000;
            trace_addr2_q <= 16'h0000;
            trace_data_q  <= 8'h00;
            trace_data2_q <= 8'h00;
            trace_write_q <= 1'b0;
        end else begin
            if (state_q == StIdle && req_valid) begin
                addr_q  <= req_addr;
                write_q <= req_write;
                wdata_q <= req_wdata;
            end
            if (lo_done && !write_q) begin
                lo_q <= mem_rdata;
            end
            if (hi_done) begin
                if (!write_q) begin
                    resp_rdata_q <= {mem_rdata, lo_q};
                end
                trace_addr_q  <= addr_q;
                trace_addr2_q <= addr_hi;
                trace_data_q  <= write_q ? wdata_q[7:0] : lo_q;
                trace_data2_q <= write_q ? wdata_q[15:8] : mem_rdata;
                trace_write_q <= write_q;
            end
        end
    end

    assign resp_rdata  = resp_rdata_q;
    assign trace_addr  = trace_addr_q;
    assign trace_addr2 = trace_addr2_q;
    assign trace_data  = trace_data_q;
    assign trace_data2 = trace_data2_q;
    assign trace_write = trace_write_q;

endmodule

// File: tb/tb_z80_word_mem_seq.sv
// Bench for z80_word_mem_seq: directed test-plan cases plus randomized transfers checked
// cycle by cycle against a timeline computed from the access rules and a byte-array memory.
module tb_z80_word_mem_seq;

    localparam int T = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_wait;
    logic [15:0] trace_addr, trace_addr2;
    logic [7:0]  trace_data, trace_data2;
    logic        trace_write;

    int tests = 0;
    int failed = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_rdata;

    always #5 clk = ~clk;

    z80_word_mem_seq #(.T_STATES(T)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_wait(mem_wait),
        .trace_addr(trace_addr), .trace_addr2(trace_addr2),
        .trace_data(trace_data), .trace_data2(trace_data2), .trace_write(trace_write)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One word transfer; entered and left 1 time unit after a rising edge.
    task automatic do_xfer(input logic w, input logic [15:0] a, input logic [15:0] wd,
                           input int wlo, input int whi, input bit hold);
        logic [15:0] a1;
        int lo_end, hi_end, n, j;
        bit in_lo, in_hi;
        a1     = a + 16'd1;
        lo_end = T + wlo;
        hi_end = 2 * T + wlo + whi;
        n      = hi_end + 1;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        mem_wait  = 1'b0;
        @(negedge clk);
        chk("ready_before_accept", 16'(req_ready), 16'h1);
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        for (int k = 1; k <= n; k++) begin
            in_lo = (k <= lo_end);
            in_hi = (k > lo_end) && (k <= hi_end);
            j     = in_lo ? k : k - lo_end;
            if (in_lo || in_hi) begin
                if (j < T) mem_wait = 1'($urandom);
                else       mem_wait = ((in_lo && k < lo_end) || (in_hi && k < hi_end));
            end else begin
                mem_wait = 1'($urandom);
            end
            if (k == lo_end)      mem_rdata = mem[a];
            else if (k == hi_end) mem_rdata = mem[a1];
            else                  mem_rdata = 8'($urandom);
            @(negedge clk);
            chk("req_ready_busy", 16'(req_ready), 16'h0);
            chk("resp_valid", 16'(resp_valid), 16'(k == n));
            chk("mem_rd", 16'(mem_rd), 16'((in_lo || in_hi) && !w));
            chk("mem_wr", 16'(mem_wr), 16'((in_lo || in_hi) && w));
            if (in_lo || in_hi) chk("mem_addr", mem_addr, in_lo ? a : a1);
            if ((in_lo || in_hi) && w) chk("mem_wdata", 16'(mem_wdata), in_lo ? 16'(wd[7:0]) : 16'(wd[15:8]));
            if (k == n) begin
                if (!w) exp_rdata = {mem[a1], mem[a]};
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("trace_addr", trace_addr, a);
                chk("trace_addr2", trace_addr2, a1);
                chk("trace_data", 16'(trace_data), w ? 16'(wd[7:0]) : 16'(mem[a]));
                chk("trace_data2", 16'(trace_data2), w ? 16'(wd[15:8]) : 16'(mem[a1]));
                chk("trace_write", 16'(trace_write), 16'(w));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", 16'(req_ready), 16'h1);
        chk("rst_mem_rd", 16'(mem_rd), 16'h0);
        chk("rst_mem_wr", 16'(mem_wr), 16'h0);
        chk("rst_resp_valid", 16'(resp_valid), 16'h0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_resp_rdata", resp_rdata, 16'h0);
        chk("rst_trace_addr", trace_addr, 16'h0);
        chk("rst_trace_data2", 16'(trace_data2), 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h1234] = 8'hCD; mem[16'h1235] = 8'hAB;
        mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        mem_rdata = 8'h00; mem_wait = 1'b0;
        exp_rdata = 16'h0000;
        reset_n = 1'b0;
        #2;
        chk_reset_outputs();
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic read, wrap-around read, wait-stretched read, write
        do_xfer(1'b0, 16'h1234, 16'h0000, 0, 0, 1'b0);
        chk("tp_read_word", resp_rdata, 16'hABCD);
        do_xfer(1'b0, 16'hFFFF, 16'h0000, 0, 0, 1'b0);
        chk("tp_wrap_word", resp_rdata, 16'h2211);
        chk("tp_wrap_addr2", trace_addr2, 16'h0000);
        do_xfer(1'b0, 16'h4000, 16'h0000, 2, 1, 1'b0);
        do_xfer(1'b1, 16'h8000, 16'hBEEF, 0, 0, 1'b0);
        chk("tp_write_rdata_kept", resp_rdata, {mem[16'h4001], mem[16'h4000]});
        chk("tp_write_trace_write", 16'(trace_write), 16'h1);

        // Reset during the high-byte access
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h2000; mem_wait = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (T + 1) begin @(posedge clk); #1; end
        chk("mid_hi_mem_rd", 16'(mem_rd), 16'h1);
        chk("mid_hi_mem_addr", mem_addr, 16'h2001);
        reset_n = 1'b0;
        #1;
        exp_rdata = 16'h0000;
        chk_reset_outputs();
        repeat (T) begin @(negedge clk); chk("rst_no_resp", 16'(resp_valid), 16'h0); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 16'(req_ready), 16'h1);
        do_xfer(1'b0, 16'h0010, 16'h0000, 0, 0, 1'b0);

        // Back-to-back with req_valid held high throughout
        do_xfer(1'b0, 16'h3000, 16'h0000, 0, 0, 1'b1);
        do_xfer(1'b0, 16'h3100, 16'h0000, 0, 0, 1'b0);

        // Randomized transfers
        for (int r = 0; r < 24; r++) begin
            do_xfer(1'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("final_idle_ready", 16'(req_ready), 16'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
